// File: rtl/seconds_event_tx_if.sv
// Event-code request link from the seconds transmitter to the event-code arbiter.
// Handshake: a code moves only in a cycle where evValid && evReady. The master keeps
// evCode stable while evValid is high and not yet accepted. It may raise evValid without
// waiting for evReady. The slave may drive evReady at any time.
interface seconds_event_tx_if;
    logic       evValid;
    logic [7:0] evCode;
    logic       evReady;

    modport master (output evValid, output evCode, input evReady);
    modport slave  (input evValid, input evCode, output evReady);
endinterface

// File: rtl/seconds_event_tx.sv
// Distributed-seconds transmitter: sends a marker code on each validated PPS.
// It then shifts out the next second's value MSB first as shift-0/shift-1 event codes.
module seconds_event_tx #(
    parameter int unsigned CLK_RATE      = 125000000,
    parameter logic [7:0]  EVCODE_SHIFT0 = 8'h70,
    parameter logic [7:0]  EVCODE_SHIFT1 = 8'h71,
    parameter logic [7:0]  EVCODE_MARKER = 8'h7D,
    parameter int unsigned BIT_SPACING   = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ppsToggle,
    input  logic                secondsValid,
    input  logic [31:0]         secondsNext,
    seconds_event_tx_if.master  ev,
    output logic                busy,
    output logic [31:0]         status,
    output logic [1:0]          dbgState
);
    localparam int unsigned SPC_W = (BIT_SPACING > 1) ? $clog2(BIT_SPACING) : 1;
    localparam logic [SPC_W-1:0] SPC_RELOAD = SPC_W'(BIT_SPACING - 1);

    // A full 33-code sequence must fit inside one second.
    if (64'(33) * 64'(BIT_SPACING) >= 64'(CLK_RATE)) begin : gRateCheck
        $error("seconds_event_tx: 33*BIT_SPACING must be below CLK_RATE");
    end
    if (BIT_SPACING < 2) begin : gSpacingCheck
        $error("seconds_event_tx: BIT_SPACING must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, MARKER, GAP, SHIFT} state_t;

    state_t           state;
    logic             ppsToggleD;
    logic             armed;
    logic             ppsEdge;
    logic             ppsEdgeQ;
    logic             evValidR;
    logic [7:0]       evCodeR;
    logic [31:0]      shiftReg;
    logic [5:0]       bitsLeft;
    logic [SPC_W-1:0] spacingCnt;
    logic [7:0]       abortCount;
    logic [7:0]       sentCount;

    assign ppsEdge = ppsToggle ^ ppsToggleD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ppsToggleD <= 1'b0;
            armed      <= 1'b0;
            ppsEdgeQ   <= 1'b0;
            evValidR   <= 1'b0;
            evCodeR    <= 8'h00;
            shiftReg   <= 32'h0;
            bitsLeft   <= 6'd0;
            spacingCnt <= '0;
            abortCount <= 8'h00;
            sentCount  <= 8'h00;
        end else begin
            ppsToggleD <= ppsToggle;
            armed      <= 1'b1;
            // The first cycle out of reset can show a false edge if ppsToggle is held high.
            ppsEdgeQ   <= ppsEdge & armed;

            if (ppsEdgeQ) begin
                if (state != IDLE && abortCount != 8'hFF)
                    abortCount <= abortCount + 8'd1;
                if (secondsValid) begin
                    state    <= MARKER;
                    shiftReg <= secondsNext;
                    bitsLeft <= 6'd32;
                    evValidR <= 1'b1;
                    evCodeR  <= EVCODE_MARKER;
                end else if (state != IDLE) begin
                    state    <= IDLE;
                    evValidR <= 1'b0;
                    bitsLeft <= 6'd0;
                end
            end else begin
                case (state)
                    MARKER: begin
                        if (ev.evReady) begin
                            evValidR   <= 1'b0;
                            spacingCnt <= SPC_RELOAD;
                            state      <= GAP;
                        end
                    end
                    GAP: begin
                        if (spacingCnt == '0) begin
                            state    <= SHIFT;
                            evValidR <= 1'b1;
                            evCodeR  <= shiftReg[31] ? EVCODE_SHIFT1 : EVCODE_SHIFT0;
                        end else begin
                            spacingCnt <= spacingCnt - SPC_W'(1);
                        end
                    end
                    SHIFT: begin
                        if (ev.evReady) begin
                            evValidR <= 1'b0;
                            shiftReg <= {shiftReg[30:0], 1'b0};
                            bitsLeft <= bitsLeft - 6'd1;
                            if (bitsLeft == 6'd1) begin
                                state     <= IDLE;
                                sentCount <= sentCount + 8'd1;
                            end else begin
                                spacingCnt <= SPC_RELOAD;
                                state      <= GAP;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ev.evValid = evValidR;
    assign ev.evCode  = evCodeR;
    assign busy       = (state != IDLE);
    assign dbgState   = state;
    assign status     = {busy, 7'b0, bitsLeft, 2'b0, abortCount, sentCount};
endmodule

// File: tb/tb_seconds_event_tx.sv
// Directed bench for seconds_event_tx: marker/shift sequence, arbiter stalls, aborts,
// suppressed PPS, reset behaviour and abort-counter saturation.
module tb_seconds_event_tx;
  localparam int BS = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ppsToggle = 1'b0;
  logic        secondsValid = 1'b0;
  logic [31:0] secondsNext = 32'h0;
  logic        busy;
  logic [31:0] status;
  logic [1:0]  dbgState;

  seconds_event_tx_if ev_if();

  seconds_event_tx #(.BIT_SPACING(BS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ppsToggle    (ppsToggle),
    .secondsValid (secondsValid),
    .secondsNext  (secondsNext),
    .ev           (ev_if.master),
    .busy         (busy),
    .status       (status),
    .dbgState     (dbgState)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cycles = 0;
  logic [7:0] exp_q[$];
  logic [7:0] acc_code[$];
  int         acc_cyc[$];

  always @(posedge clk) begin
    cyc++;
    if (ev_if.evValid === 1'b1) valid_cycles++;
    if (rst_n && ev_if.evValid === 1'b1 && ev_if.evReady === 1'b1) begin
      acc_code.push_back(ev_if.evCode);
      acc_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic toggle_pps();
    @(negedge clk);
    ppsToggle = ~ppsToggle;
  endtask

  task automatic clear_sb();
    exp_q.delete();
    acc_code.delete();
    acc_cyc.delete();
  endtask

  task automatic push_seq(input logic [31:0] v, input int nbits);
    exp_q.push_back(8'h7D);
    for (int i = 31; i > 31 - nbits; i--)
      exp_q.push_back(v[i] ? 8'h71 : 8'h70);
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int k = 0;
    while (acc_code.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, acc_code.size(), n);
  endtask

  task automatic check_codes(input string tag);
    logic [31:0] obs;
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < acc_code.size()) ? {24'h0, acc_code[i]} : 32'hxxxx_xxxx;
      check($sformatf("%s_code%0d", tag, i), obs, {24'h0, exp_q[i]});
    end
  endtask

  task automatic check_gaps(input string tag, input int first, input int last, input int gap);
    logic [31:0] obs;
    for (int i = first; i <= last; i++) begin
      obs = (i < acc_cyc.size()) ? 32'(acc_cyc[i] - acc_cyc[i-1]) : 32'hxxxx_xxxx;
      check($sformatf("%s_gap%0d", tag, i), obs, gap);
    end
  endtask

  task automatic idle_watch(input int n, output int busy_seen);
    busy_seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen++;
    end
  endtask

  initial begin
    int v0;
    int busy_seen;
    int unstable;
    int k;
    logic [7:0] code0;

    ev_if.evReady = 1'b0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_evValid", ev_if.evValid, 0);
    check("rst_evCode", ev_if.evCode, 0);
    check("rst_busy", busy, 0);
    check("rst_status", status, 0);
    check("rst_state", dbgState, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // basic sequence, arbiter always ready
    clear_sb();
    secondsValid = 1'b1;
    ev_if.evReady = 1'b1;
    secondsNext = 32'h8000_0001;
    push_seq(32'h8000_0001, 32);
    toggle_pps();
    @(negedge clk);
    check("t1_lat1_evValid", ev_if.evValid, 0);
    @(negedge clk);
    check("t1_lat2_evValid", ev_if.evValid, 1);
    check("t1_lat2_evCode", ev_if.evCode, 32'h7D);
    wait_acc(33, 600, "t1_count");
    check_codes("t1");
    check_gaps("t1", 1, 32, BS + 1);
    repeat (2) @(negedge clk);
    check("t1_busy", busy, 0);
    check("t1_status", status, 32'h0000_0001);

    // arbiter stalls 20 clocks on every request
    clear_sb();
    ev_if.evReady = 1'b0;
    push_seq(32'h8000_0001, 32);
    unstable = 0;
    toggle_pps();
    for (int n = 0; n < 33; n++) begin
      k = 0;
      while (ev_if.evValid !== 1'b1 && k < 60) begin
        @(negedge clk);
        k++;
      end
      check($sformatf("t2_req%0d", n), ev_if.evValid, 1);
      code0 = ev_if.evCode;
      repeat (20) begin
        @(negedge clk);
        if (ev_if.evValid !== 1'b1 || ev_if.evCode !== code0) unstable++;
      end
      ev_if.evReady = 1'b1;
      @(posedge clk);
      #1 ev_if.evReady = 1'b0;
    end
    check("t2_stable", unstable, 0);
    check_codes("t2");
    check_gaps("t2", 1, 32, BS + 21);
    repeat (2) @(negedge clk);
    check("t2_status", status, 32'h0000_0002);

    // early PPS after 10 bits aborts and restarts with the new value
    clear_sb();
    ev_if.evReady = 1'b1;
    secondsNext = 32'hA5A5_0F0F;
    push_seq(32'hA5A5_0F0F, 10);
    push_seq(32'h1234_5678, 32);
    toggle_pps();
    wait_acc(11, 300, "t3_count11");
    secondsNext = 32'h1234_5678;
    ppsToggle = ~ppsToggle;
    wait_acc(44, 600, "t3_count44");
    check_codes("t3");
    repeat (2) @(negedge clk);
    check("t3_status", status, 32'h0000_0103);

    // PPS without valid seconds emits nothing
    secondsValid = 1'b0;
    v0 = valid_cycles;
    toggle_pps();
    idle_watch(40, busy_seen);
    check("t4_valid_cycles", valid_cycles - v0, 0);
    check("t4_busy_seen", busy_seen, 0);
    check("t4_status", status, 32'h0000_0103);

    // ppsToggle held high across reset release
    ppsToggle = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    secondsValid = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cycles;
    idle_watch(30, busy_seen);
    check("t5_valid_cycles", valid_cycles - v0, 0);
    check("t5_busy_seen", busy_seen, 0);
    check("t5_status", status, 0);
    ev_if.evReady = 1'b0;
    toggle_pps();
    repeat (2) @(negedge clk);
    check("t5_marker_valid", ev_if.evValid, 1);
    check("t5_marker_code", ev_if.evCode, 32'h7D);
    ev_if.evReady = 1'b1;
    @(posedge clk);
    #1 ev_if.evReady = 1'b0;
    @(negedge clk);
    k = 0;
    while (ev_if.evValid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("t5_shift_code", ev_if.evCode, 32'h70);
    check("t5_shift_state", dbgState, 3);

    // asynchronous reset mid-SHIFT
    #2 rst_n = 1'b0;
    #1;
    check("t5_arst_evValid", ev_if.evValid, 0);
    check("t5_arst_evCode", ev_if.evCode, 0);
    check("t5_arst_status", status, 0);
    check("t5_arst_state", dbgState, 0);

    // abortCount saturation
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    toggle_pps();
    for (int i = 0; i < 100; i++) toggle_pps();
    repeat (4) @(negedge clk);
    check("t6_abort100", status[15:8], 100);
    check("t6_busy", busy, 1);
    for (int i = 0; i < 200; i++) toggle_pps();
    repeat (4) @(negedge clk);
    check("t6_abort_sat", status[15:8], 255);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
